hazard_controller: RTL

Pipeline hazard controller for the 5-stage RISC-V core. It detects load-use hazards and taken-branch redirects and drives the stall and flush controls of the pipeline registers. It also sequences the shared iterative multiply/divide unit (MDU) from the EX stage: it launches the MDU, freezes the front of the pipeline while the MDU is busy, and releases the pipeline on completion or on watchdog timeout. It sits beside the forwarding logic and is the only source of StallF/StallD/StallE/FlushD/FlushE/FlushM.

---
 rtl/hazard_controller.sv | 89 ++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// Hazard controller: load-use and branch stall/flush generation,
// plus MDU launch/hold sequencing with a watchdog.
module hazard_controller #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MulDivE,
  input  logic             mdu_done,
  output logic             mdu_start,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WC_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WC_W-1:0] LIMIT = WC_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic            lw_stall;
  logic            mdu_stall;
  logic            run;

  always_comb begin
    run       = ~reset;
    lw_stall  = ResultSrcE0 && (RdE != 5'd0)
              && ((Rs1D == RdE) || (Rs2D == RdE));
    mdu_stall = ((state == IDLE) && MulDivE) || (state == BUSY);
    // MDU hold wins so the held EX instruction is never flushed
    mdu_start = run && (state == IDLE) && MulDivE;
    StallF    = run && (lw_stall || mdu_stall);
    StallD    = StallF;
    StallE    = run && mdu_stall;
    FlushM    = StallE;
    FlushD    = run && PCSrcE && !mdu_stall;
    FlushE    = run && (lw_stall || PCSrcE) && !mdu_stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      mdu_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (MulDivE) begin
            state    <= BUSY;
            wait_cnt <= '0;
          end
        end
        BUSY: begin
          if (mdu_done) begin
            state <= DONE;
          end else if (wait_cnt == LIMIT) begin
            state       <= DONE;
            mdu_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (StallF && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
